// File: rtl/contador_lectura.sv
// rtl/contador_lectura.sv - per-class saturating event counters with a 4-phase req/valid read port
module contador_lectura #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evt_valid,
    input  logic [1:0]       evt_class,
    input  logic             req,
    input  logic [1:0]       idx,
    input  logic             clear_on_read,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy
);

    // Bit 0 set means "not idle", so busy comes straight from one flop and cannot glitch.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RESP = 2'b01,
        HOLD = 2'b11
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt [4];
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic             w_capture;
    logic [3:0]       w_hit;
    logic [3:0]       w_clr;

    assign w_capture = (r_state == IDLE) && req;

    // Per-class event hit and clear-at-capture decode.
    always_comb begin
        w_hit = 4'b0000;
        w_clr = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_hit[i] = evt_valid && (evt_class == 2'(i));
            w_clr[i] = w_capture && clear_on_read && (idx == 2'(i));
        end
    end

    // Counters run regardless of the read FSM; a clear keeps a same-edge event as count 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_clr[i]) begin
                    r_cnt[i] <= WIDTH'(w_hit[i]);
                end else if (w_hit[i] && (r_cnt[i] != {WIDTH{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Read handshake: capture in IDLE, pulse valid for one cycle, wait for req to fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (req) begin
                        r_data  <= r_cnt[idx];
                        r_valid <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_valid <= 1'b0;
                    r_state <= req ? HOLD : IDLE;
                end
                HOLD: begin
                    r_valid <= 1'b0;
                    if (!req) r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign busy  = r_state[0];

endmodule

// File: tb/tb_contador_lectura.sv
// tb/tb_contador_lectura.sv - directed self-checking bench for contador_lectura
module tb_contador_lectura;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        evt_valid = 1'b0;
    logic [1:0]  evt_class = 2'd0;
    logic        req = 1'b0;
    logic [1:0]  idx = 2'd0;
    logic        clear_on_read = 1'b0;
    logic [15:0] data;
    logic        valid;
    logic        busy;
    logic [3:0]  data_n;
    logic        valid_n;
    logic        busy_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    contador_lectura #(.WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .evt_valid(evt_valid), .evt_class(evt_class),
        .req(req), .idx(idx), .clear_on_read(clear_on_read),
        .data(data), .valid(valid), .busy(busy)
    );

    contador_lectura #(.WIDTH(4)) u_dut_n (
        .clk(clk), .reset(reset), .evt_valid(evt_valid), .evt_class(evt_class),
        .req(req), .idx(idx), .clear_on_read(clear_on_read),
        .data(data_n), .valid(valid_n), .busy(busy_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        evt_valid = 1'b0;
        req = 1'b0;
        clear_on_read = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic send_events(input logic [1:0] cls, input int n);
        evt_valid = 1'b1;
        evt_class = cls;
        repeat (n) tick();
        evt_valid = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] k, input logic c,
                           output logic [15:0] d, output logic [3:0] dn,
                           output logic v1, output logic v2);
        req = 1'b1;
        idx = k;
        clear_on_read = c;
        tick();
        d  = data;
        dn = data_n;
        v1 = valid;
        req = 1'b0;
        clear_on_read = 1'b0;
        tick();
        v2 = valid;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_cmp++; if (data !== 16'd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", data); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        apply_reset();
    endtask

    task automatic test_count_basic();
        logic [15:0] d; logic [3:0] dn; logic v1, v2;
        apply_reset();
        send_events(2'd2, 3);
        send_events(2'd0, 1);
        do_read(2'd2, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd3) begin n_err++; $display("FAIL basic_data2: got %0d want 3", d); end
        n_cmp++; if (v1 !== 1'b1) begin n_err++; $display("FAIL basic_valid_hi: got %b want 1", v1); end
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL basic_valid_lo: got %b want 0", v2); end
        do_read(2'd0, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd1) begin n_err++; $display("FAIL basic_data0: got %0d want 1", d); end
        do_read(2'd2, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd3) begin n_err++; $display("FAIL basic_reread2: got %0d want 3", d); end
    endtask

    task automatic test_same_edge();
        logic [15:0] d; logic [3:0] dn; logic v1, v2;
        apply_reset();
        send_events(2'd1, 5);
        evt_valid = 1'b1; evt_class = 2'd1;
        req = 1'b1; idx = 2'd1;
        tick();
        evt_valid = 1'b0;
        n_cmp++; if (data !== 16'd5) begin n_err++; $display("FAIL same_edge_data: got %0d want 5", data); end
        req = 1'b0;
        tick();
        do_read(2'd1, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd6) begin n_err++; $display("FAIL same_edge_next: got %0d want 6", d); end
    endtask

    task automatic test_clear_race();
        logic [15:0] d; logic [3:0] dn; logic v1, v2;
        apply_reset();
        send_events(2'd3, 7);
        send_events(2'd0, 2);
        send_events(2'd1, 4);
        evt_valid = 1'b1; evt_class = 2'd3;
        req = 1'b1; idx = 2'd3; clear_on_read = 1'b1;
        tick();
        evt_valid = 1'b0; clear_on_read = 1'b0;
        n_cmp++; if (data !== 16'd7) begin n_err++; $display("FAIL clr_race_data: got %0d want 7", data); end
        req = 1'b0;
        tick();
        do_read(2'd3, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd1) begin n_err++; $display("FAIL clr_race_next: got %0d want 1", d); end
        do_read(2'd0, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd2) begin n_err++; $display("FAIL clr_race_cnt0: got %0d want 2", d); end
        do_read(2'd1, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd4) begin n_err++; $display("FAIL clr_race_cnt1: got %0d want 4", d); end
        do_read(2'd2, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd0) begin n_err++; $display("FAIL clr_race_cnt2: got %0d want 0", d); end
    endtask

    task automatic test_saturation();
        logic [15:0] d; logic [3:0] dn; logic v1, v2;
        apply_reset();
        send_events(2'd1, 20);
        do_read(2'd1, 1'b0, d, dn, v1, v2);
        n_cmp++; if (dn !== 4'd15) begin n_err++; $display("FAIL sat_narrow: got %0d want 15", dn); end
        n_cmp++; if (d !== 16'd20) begin n_err++; $display("FAIL sat_wide: got %0d want 20", d); end
        do_read(2'd1, 1'b1, d, dn, v1, v2);
        n_cmp++; if (dn !== 4'd15) begin n_err++; $display("FAIL sat_clr_read: got %0d want 15", dn); end
        do_read(2'd1, 1'b0, d, dn, v1, v2);
        n_cmp++; if (dn !== 4'd0) begin n_err++; $display("FAIL sat_after_clr: got %0d want 0", dn); end
        n_cmp++; if (d !== 16'd0) begin n_err++; $display("FAIL sat_wide_after_clr: got %0d want 0", d); end
    endtask

    task automatic test_handshake();
        int pulses;
        int busy_hi;
        apply_reset();
        pulses = 0; busy_hi = 0;
        req = 1'b1; idx = 2'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid === 1'b1) pulses++;
            if (busy === 1'b1) busy_hi++;
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL hs_held_pulses: got %0d want 1", pulses); end
        n_cmp++; if (busy_hi != 6) begin n_err++; $display("FAIL hs_held_busy: got %0d cycles want 6", busy_hi); end
        req = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hs_busy_release: got %b want 0", busy); end
        pulses = 0;
        req = 1'b1; tick(); if (valid === 1'b1) pulses++;
        req = 1'b0; tick(); if (valid === 1'b1) pulses++;
        req = 1'b1; tick(); if (valid === 1'b1) pulses++;
        req = 1'b0; tick(); if (valid === 1'b1) pulses++;
        n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL hs_two_reads: got %0d pulses want 2", pulses); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hs_idle_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d; logic [3:0] dn; logic v1, v2;
        apply_reset();
        send_events(2'd0, 3);
        req = 1'b1; idx = 2'd0;
        tick();
        n_cmp++; if (data !== 16'd3 || valid !== 1'b1) begin n_err++; $display("FAIL mid_pre: got data %0d valid %b want 3/1", data, valid); end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (data !== 16'd0) begin n_err++; $display("FAIL mid_data: got %0d want 0", data); end
        req = 1'b0;
        tick();
        reset = 1'b1;
        do_read(2'd0, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd0 || v1 !== 1'b1) begin n_err++; $display("FAIL mid_after0: got %0d valid %b want 0/1", d, v1); end
        do_read(2'd3, 1'b0, d, dn, v1, v2);
        n_cmp++; if (d !== 16'd0) begin n_err++; $display("FAIL mid_after3: got %0d want 0", d); end
    endtask

    initial begin
        test_reset();
        test_count_basic();
        test_same_edge();
        test_clear_race();
        test_saturation();
        test_handshake();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/contador_lectura.md
# contador_lectura

Per-class event counter with a request/acknowledge read port. It counts events in four traffic classes (class = 2-bit code) and hands any class count to a reader through a 4-phase req/valid handshake, with optional clear-on-read. It sits on the consumer side of the transaction-layer counter path: the producer drives class codes, and this block returns the counts.

## Interface
- WIDTH, 16, width of each class counter and of `data`.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- evt_valid  input  1  an event is present this cycle.
- evt_class  input  2  class of the event (0..3); ignored when evt_valid=0.
- req  input  1  read request; level signal, 4-phase.
- idx  input  2  class to read; sampled with req.
- clear_on_read  input  1  when 1, the read class counter is cleared at capture.
- data  output  WIDTH  captured count; holds until the next capture.
- valid  output  1  one-cycle pulse, data is new.
- busy  output  1  high whenever state != IDLE.

## Operation
- Four counters cnt[0..3], WIDTH bits, unsigned.
- Counting runs in every state, independent of the read FSM.
- At each edge with evt_valid=1: cnt[evt_class] += 1, saturating at 2^WIDTH-1 (no wrap).
- FSM states: IDLE, RESP, HOLD.
  - IDLE: if req=1 at an edge, capture data <= cnt[idx], valid <= 1, and go to RESP. Otherwise stay.
  - RESP: valid <= 0. Go to HOLD if req=1, else go to IDLE.
  - HOLD: go to IDLE when req=0. req is ignored here, so no new capture happens.
- The captured value is the counter value before the capture edge. An event sampled on the same edge is not included in data.
- Clear-on-read, at the capture edge with clear_on_read=1:
  - cnt[idx] <= 1 if a same-class event arrives on that edge, else 0. No event is lost.
  - Other classes update normally.
- Without clear_on_read, a read does not modify any counter.
- idx and clear_on_read matter only on the capture edge.
- busy is decoded from the state register and is glitch-free.

## Timing
- Reset (reset=0), asynchronous: cnt[*]=0, data=0, valid=0, busy=0, state=IDLE.
- Release of reset is synchronous to clk in the surrounding design. The first counted event is the one sampled on the first edge after release.
- Read latency: req sampled high at edge N means data and valid=1 are visible after edge N, and valid drops after edge N+1.
- Minimum request spacing: req must fall and be sampled low (RESP→IDLE or HOLD→IDLE) before the next capture. Back-to-back reads therefore take at least 2 cycles each.
- req held high continuously produces exactly one valid pulse.
- Counters see an event one edge after evt_valid is sampled. A read at edge N+1 includes an event sampled at edge N.
- Saturation: at cnt=2^WIDTH-1, further events leave the value unchanged. Clear-on-read still clears it.
- Reset asserted mid-operation (RESP or HOLD): valid and busy drop immediately, data=0, and all counts are lost.

## Test plan
- Count basic: reset, release; 3 events class 2, 1 event class 0; req with idx=2 → data=3 and valid=1 for exactly one cycle; then idx=0 → data=1.
- Same-edge event: the capture edge for idx=1 coincides with a class-1 event, cnt[1]=5 before the edge → data=5; the next read returns 6.
- Clear-on-read race: cnt[3]=7, clear_on_read=1, class-3 event on the capture edge → data=7; the next read returns 1; cnt[0..2] unchanged.
- Saturation: WIDTH=4, 20 events class 1 → read returns 15. Then clear_on_read read → 15; next read → 0.
- Handshake: req held high for 6 cycles → one valid pulse, busy high until req is sampled low, then busy=0. Two reads with req low for one cycle between them → two pulses.
- Reset mid-read: assert reset=0 while in RESP → valid=0, busy=0, data=0 without a clock edge. After release, a read of any class returns 0.
